// File: rtl/eight_way_demux_reg.sv
// Registered 1-to-8 word distributor with per-lane valid/ack hand-back; accept updates lanes after one edge.
// Optional broadcast-to-all-lanes via EIGHT_WAY_DEMUX_BCAST_EN; in_ready is combinational from sel/valid/ack.
module eight_way_demux_reg #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      sel,
  input  logic [SIZE-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      ack,
  output logic [7:0]      valid,
  output logic [SIZE-1:0] out_a,
  output logic [SIZE-1:0] out_b,
  output logic [SIZE-1:0] out_c,
  output logic [SIZE-1:0] out_d,
  output logic [SIZE-1:0] out_e,
  output logic [SIZE-1:0] out_f,
  output logic [SIZE-1:0] out_g,
  output logic [SIZE-1:0] out_h,
`ifdef EIGHT_WAY_DEMUX_BCAST_EN
  input  logic            bcast,
`endif
  output logic [7:0]      cnt
);

  logic [SIZE-1:0] lane [8];
  logic [7:0]      free;
  logic [7:0]      onehot;
  logic [7:0]      wr_en;
  logic            accept;

  // A full lane being acked this cycle can be refilled in the same cycle.
  assign free   = ~valid | ack;
  assign onehot = 8'b0000_0001 << sel;

`ifdef EIGHT_WAY_DEMUX_BCAST_EN
  assign in_ready = bcast ? (&free) : free[sel];
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept ? (bcast ? 8'hFF : onehot) : 8'h00;
`else
  assign in_ready = free[sel];
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept ? onehot : 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) lane[i] <= '0;
      valid <= 8'h00;
      cnt   <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) lane[i] <= in;
      end
      // Consumed lanes keep their data; only the flag drops.
      valid <= (valid & ~ack) | wr_en;
      if (accept) cnt <= cnt + 8'd1;
    end
  end

  assign out_a = lane[0];
  assign out_b = lane[1];
  assign out_c = lane[2];
  assign out_d = lane[3];
  assign out_e = lane[4];
  assign out_f = lane[5];
  assign out_g = lane[6];
  assign out_h = lane[7];

endmodule

// File: tb/tb_eight_way_demux_reg.sv
// Scoreboard bench for eight_way_demux_reg: driver pushes predicted post-edge state, monitor pops and compares.
module tb_eight_way_demux_reg;

  typedef struct packed {
    logic [7:0]   v;
    logic [7:0]   c;
    logic [127:0] d;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [2:0]  sel;
  logic [15:0] in;
  logic [7:0]  ack, valid, cnt;
  logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
`ifdef EIGHT_WAY_DEMUX_BCAST_EN
  logic        bcast;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lane contents, occupancy and accepted-word count.
  logic [15:0] md [8];
  logic [7:0]  mv;
  int          mc;
  snap_t       q [$];

  always #5 clk = ~clk;

  eight_way_demux_reg #(.SIZE(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .ack(ack), .valid(valid),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_e(out_e), .out_f(out_f), .out_g(out_g), .out_h(out_h),
`ifdef EIGHT_WAY_DEMUX_BCAST_EN
    .bcast(bcast),
`endif
    .cnt(cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_data();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = md[i];
    return r;
  endfunction

  // Drive one cycle of stimulus, check the combinational ready, predict the post-edge state.
  task automatic step(input logic r, input logic iv, input logic [2:0] s,
                      input logic [15:0] d, input logic [7:0] a, input logic bc);
    logic rdy;
    logic all_free;
    snap_t e;
    @(negedge clk);
    rst = r; in_valid = iv; sel = s; in = d; ack = a;
`ifdef EIGHT_WAY_DEMUX_BCAST_EN
    bcast = bc;
`endif
    #1;
    all_free = 1'b1;
    for (int i = 0; i < 8; i++) if (mv[i] && !a[i]) all_free = 1'b0;
    rdy = bc ? all_free : (!mv[s] || a[s]);
    chk("in_ready", {127'd0, in_ready}, {127'd0, rdy});
    if (r) begin
      for (int i = 0; i < 8; i++) md[i] = 16'h0;
      mv = 8'h00;
      mc = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (iv && rdy && (bc || s == 3'(i))) begin
          md[i] = d;
          mv[i] = 1'b1;
        end else if (a[i]) begin
          mv[i] = 1'b0;
        end
      end
      if (iv && rdy) mc = (mc + 1) % 256;
    end
    e.v = mv; e.c = 8'(mc); e.d = model_data();
    q.push_back(e);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle with a prediction outstanding, compare the registered outputs.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid", {120'd0, valid}, {120'd0, e.v});
        chk("cnt", {120'd0, cnt}, {120'd0, e.c});
        chk("lanes", {out_h, out_g, out_f, out_e, out_d, out_c, out_b, out_a}, e.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) md[i] = 16'h0;
    mv = 8'h00; mc = 0;
    rst = 1'b1; in_valid = 1'b0; sel = 3'd0; in = 16'h0; ack = 8'h00;
`ifdef EIGHT_WAY_DEMUX_BCAST_EN
    bcast = 1'b0;
`endif

    // Reset and first accept into lane C.
    step(1, 0, 3'd0, 16'h0, 8'h00, 0);
    step(1, 0, 3'd0, 16'h0, 8'h00, 0);
    post_edge();
    chk("reset_valid", {120'd0, valid}, 128'h0);
    chk("reset_ready", {127'd0, in_ready}, 128'h1);
    step(0, 1, 3'd2, 16'h1234, 8'h00, 0);
    post_edge();
    chk("first_out_c", {112'd0, out_c}, {112'd0, 16'h1234});
    chk("first_valid", {120'd0, valid}, {120'd0, 8'h04});
    chk("first_cnt", {120'd0, cnt}, 128'd1);

    // Blocked request on full lane C, then consume-and-refill.
    step(0, 1, 3'd2, 16'hBEEF, 8'h00, 0);
    chk("blocked_ready", {127'd0, in_ready}, 128'h0);
    post_edge();
    chk("blocked_out_c", {112'd0, out_c}, {112'd0, 16'h1234});
    step(0, 1, 3'd2, 16'hBEEF, 8'h04, 0);
    chk("refill_ready", {127'd0, in_ready}, 128'h1);
    post_edge();
    chk("refill_out_c", {112'd0, out_c}, {112'd0, 16'hBEEF});

    // Fill all lanes from reset, then partial multi-lane ack.
    step(1, 0, 3'd0, 16'h0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 16'(i), 8'h00, 0);
    post_edge();
    chk("fill_valid", {120'd0, valid}, {120'd0, 8'hFF});
    chk("fill_out_h", {112'd0, out_h}, {112'd0, 16'h0007});
    chk("fill_cnt", {120'd0, cnt}, 128'd8);
    step(0, 0, 3'd0, 16'h0, 8'hA5, 0);
    post_edge();
    chk("ack_a5_valid", {120'd0, valid}, {120'd0, 8'h5A});

    // Counter wrap: run the count to 255, then one more accept.
    while (mc != 255) step(0, 1, 3'd0, 16'($urandom), 8'h01, 0);
    post_edge();
    chk("cnt_255", {120'd0, cnt}, 128'd255);
    step(0, 1, 3'd0, 16'h5555, 8'h01, 0);
    post_edge();
    chk("cnt_wrap", {120'd0, cnt}, 128'd0);

    // Reset wins over accept and acks.
    step(1, 0, 3'd0, 16'h0, 8'h00, 0);
    for (int i = 2; i < 6; i++) step(0, 1, 3'(i), 16'hC000 + 16'(i), 8'h00, 0);
    post_edge();
    chk("pre_rst_valid", {120'd0, valid}, {120'd0, 8'h3C});
    step(1, 1, 3'd1, 16'hFFFF, 8'hFF, 0);
    post_edge();
    chk("rst_valid", {120'd0, valid}, 128'h0);
    chk("rst_cnt", {120'd0, cnt}, 128'h0);
    chk("rst_lanes", {out_h, out_g, out_f, out_e, out_d, out_c, out_b, out_a}, 128'h0);

`ifdef EIGHT_WAY_DEMUX_BCAST_EN
    step(0, 1, 3'd3, 16'hA5A5, 8'h00, 1);
    post_edge();
    chk("bcast_lanes", {out_h, out_g, out_f, out_e, out_d, out_c, out_b, out_a}, {8{16'hA5A5}});
    chk("bcast_valid", {120'd0, valid}, {120'd0, 8'hFF});
    chk("bcast_cnt", {120'd0, cnt}, 128'd1);
    step(0, 0, 3'd0, 16'h0, 8'hEF, 0);
    step(0, 1, 3'd0, 16'h1111, 8'h00, 1);
    chk("bcast_blocked", {127'd0, in_ready}, 128'h0);
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      logic bc;
      bc = 1'b0;
`ifdef EIGHT_WAY_DEMUX_BCAST_EN
      bc = ($urandom_range(0, 7) == 0);
`endif
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, 3'($urandom),
           16'($urandom), 8'($urandom) & 8'($urandom), bc);
    end
    step(0, 0, 3'd0, 16'h0, 8'h00, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eight_way_demux_reg.md
# eight_way_demux_reg

Registered 1-to-8 word distributor: the write-side counterpart of the datapath's 8:1 select mux. It accepts one SIZE-bit word per handshake and routes it into one of eight holding registers (lanes A–H) selected by a 3-bit code. Each lane keeps its word and a valid flag until its consumer acknowledges it, which gives per-destination back-pressure. It sits between the 16-bit result bus and eight downstream consumers: register-file ports, address latches, and similar.

## Interface

- SIZE, 16, word width of the input and of every lane register
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- SEL  input  3  destination lane: 3'b000=A, 001=B, 010=C, 011=D, 100=E, 101=F, 110=G, 111=H
- IN  input  SIZE  word to distribute
- IN_VALID  input  1  IN/SEL are presented this cycle
- IN_READY  output  1  the lane addressed by SEL can take a word this cycle (combinational)
- ACK  input  8  per-lane consume strobe; bit 0 = A … bit 7 = H
- VALID  output  8  per-lane occupied flag; bit 0 = A … bit 7 = H
- OUT_A … OUT_H  output  SIZE each  lane holding registers
- CNT  output  8  count of accepted words, modulo 256
- BCAST  input  1  broadcast request; present only with BCAST macro (see Configuration)

## Operation

- Lane n is free when VALID[n]=0. It is also free when VALID[n]=1 and ACK[n]=1 in the same cycle (consume and refill).
- IN_READY = lane SEL free. IN_READY does not depend on IN_VALID.
- Accept = IN_VALID & IN_READY. On accept:
  - OUT_<SEL> <= IN
  - VALID[SEL] <= 1
  - CNT <= CNT+1 (wraps 255→0)
- Per lane, ACK[n] with VALID[n]=1 and no accept to lane n clears VALID[n]. OUT_n keeps its last value, so no data is cleared on consume.
- ACK[n] with VALID[n]=0 is ignored.
- Acks on several lanes in one cycle are each honoured independently.
- A simultaneous ack and accept on the same lane leaves VALID[n]=1 and loads the new word.
- While VALID[n]=1 and there is no accept, OUT_n is stable.
- SEL and IN are don't-care when IN_VALID=0. CNT does not change.
- A blocked request (IN_VALID=1, IN_READY=0) has no side effects. The source must hold it until it is accepted.
- There is no state machine beyond the eight lane flags. Each lane has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on ACK without accept.
  - FULL → FULL on ACK with accept.

## Timing

- Reset values: OUT_A..OUT_H=0, VALID=8'h00, CNT=8'h00. IN_READY=1 in the cycle after reset, because all lanes are empty.
- RST takes priority over every other input in the same cycle. A mid-operation reset discards all held words and any pending acks.
- Latency: accept at edge k. OUT_<SEL>, VALID and CNT show the new values after edge k.
- Throughput: one word per cycle to distinct lanes. One word per cycle to the same lane only if its consumer acks every cycle.
- IN_READY is combinational from SEL, VALID and ACK. No combinational path exists from IN or IN_VALID to any output.

## Configuration

- Macro: EIGHT_WAY_DEMUX_BCAST_EN.
- When defined:
  - The BCAST port exists.
  - With BCAST=1, IN_READY = all eight lanes free.
  - Accept writes IN to every lane and sets VALID=8'hFF.
  - CNT increments by 1.
  - SEL is ignored.
- When undefined:
  - The BCAST port is absent.
  - Behaviour is exactly the single-lane routing above.

## Test plan

- Reset, then check outputs. Then IN=16'h1234, SEL=3'b010, IN_VALID=1 for one cycle. Required: OUT_C=16'h1234, VALID=8'h04, CNT=1, all other lanes 0.
- Lane C full, SEL=3'b010, IN=16'hBEEF, ACK=0. Required: IN_READY=0, OUT_C stays 16'h1234, CNT unchanged. Next cycle with ACK[2]=1: IN_READY=1, then OUT_C=16'hBEEF, VALID[2]=1.
- Fill all eight lanes with 16'h0000..16'h0007 on consecutive cycles (SEL=0..7). Required: VALID=8'hFF, OUT_H=16'h0007, CNT=8. Then ACK=8'hA5. Required: VALID=8'h5A.
- Preload CNT=255 (255 accepts with acks), then one more accept. Required: CNT=0.
- Assert RST while VALID=8'h3C, in the same cycle as IN_VALID=1 and ACK=8'hFF. Required: VALID=0, all OUT=0, CNT=0 the next cycle.
- BCAST macro defined, all lanes empty: BCAST=1, IN=16'hA5A5. Required: all OUT=16'hA5A5, VALID=8'hFF, CNT+1. Repeat with lane E full and no ack. Required: IN_READY=0.
